// File: rtl/arb_wb_pkg.sv
`default_nettype none
//============================================================================
// Package  : arb_wb_pkg
// Purpose  : Shared types and default dimensions for the posted write-back
//            buffer between the L1 arbiter and the L2 cache.
// Contents : state_t     - controller states
//            wb_entry_t  - one buffered line at the default dimensions
//            LINE_ADDR_W - line-address width at the default dimensions
// Revision : 1.0 - initial release
//============================================================================
package arb_wb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_LINE_W      = 256;
  localparam int DEF_OFFSET_BITS = 5;
  localparam int DEF_DEPTH       = 4;

  localparam int LINE_ADDR_W = DEF_ADDR_W - DEF_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    L2_RD = 2'd2,
    L2_WR = 2'd3
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] line_addr;
    logic [DEF_LINE_W-1:0]  data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo_cam.sv
`default_nettype none
//============================================================================
// Module   : wb_fifo_cam
// Purpose  : Entry storage for the write-back buffer. A circular FIFO
//            (head = oldest) whose line addresses are also searched in
//            parallel so reads and writes can find a buffered line.
// Ports    : clk, rst_n                 clock, async active-low reset
//            i_lookup_line              line address to search for
//            o_hit/o_hit_idx/o_hit_data match result (at most one entry)
//            i_push/i_push_line/_data   append a new line at the tail
//            i_pop                      retire the head entry
//            i_merge_en/_idx/_data      overwrite data of an existing entry
//            o_full/o_empty             occupancy flags
//            o_head_line/o_head_data    oldest entry, next to drain
// Revision : 1.0 - initial release
//============================================================================
module wb_fifo_cam
  import arb_wb_pkg::*;
#(
  parameter  int LA_W   = LINE_ADDR_W,
  parameter  int LINE_W = DEF_LINE_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LA_W-1:0]   i_lookup_line,
  output logic              o_hit,
  output logic [PTR_W-1:0]  o_hit_idx,
  output logic [LINE_W-1:0] o_hit_data,
  input  logic              i_push,
  input  logic [LA_W-1:0]   i_push_line,
  input  logic [LINE_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_merge_en,
  input  logic [PTR_W-1:0]  i_merge_idx,
  input  logic [LINE_W-1:0] i_merge_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LA_W-1:0]   o_head_line,
  output logic [LINE_W-1:0] o_head_data
);

  localparam int C_CNT_W = PTR_W + 1;

  logic              r_valid [DEPTH];
  logic [LA_W-1:0]   r_line  [DEPTH];
  logic [LINE_W-1:0] r_data  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [C_CNT_W-1:0] r_count;
  logic [DEPTH-1:0]  w_match;

  // Parallel compare of every entry against the lookup line.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match[gi] = r_valid[gi] && (r_line[gi] == i_lookup_line);
  end

  // Lines are unique in the buffer, so a plain encoder is enough.
  always_comb begin
    o_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i]) o_hit_idx = PTR_W'(i);
    end
  end

  assign o_hit       = |w_match;
  assign o_hit_data  = r_data[o_hit_idx];
  assign o_full      = (r_count == C_CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_line = r_line[r_head];
  assign o_head_data = r_data[r_head];

  // Push, pop and merge come from different controller states, so at most
  // one of them is active in any cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_line[i]  <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (r_tail == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_line[i]  <= i_push_line;
          r_data[i]  <= i_push_data;
        end else if (i_merge_en && (i_merge_idx == PTR_W'(i))) begin
          r_data[i]  <= i_merge_data;
        end else if (i_pop && (r_head == PTR_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_tail  <= r_tail + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (i_pop) begin
      r_head  <= r_head + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbiter_write_buffer.sv
`default_nettype none
//============================================================================
// Module   : arbiter_write_buffer
// Purpose  : Posted write-back buffer between the L1 arbiter and L2.
//            Writes are acknowledged once captured and drained to L2 in
//            FIFO order when the port is free; reads are served from the
//            buffer on a hit and forwarded to L2 on a miss.
// Ports    : clk, rst_n                       clock, async active-low reset
//            arb_read/arb_write/arb_addr/
//            arb_wdata                        arbiter request (held to resp)
//            arb_rdata/arb_resp               arbiter completion
//            l2_read/l2_write/l2_addr/
//            l2_wdata                         L2 request (held to l2_resp)
//            l2_rdata/l2_resp                 L2 completion
// Revision : 1.0 - initial release
//============================================================================
module arbiter_write_buffer
  import arb_wb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LINE_W      = DEF_LINE_W,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arb_read,
  input  logic              arb_write,
  input  logic [ADDR_W-1:0] arb_addr,
  input  logic [LINE_W-1:0] arb_wdata,
  output logic [LINE_W-1:0] arb_rdata,
  output logic              arb_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  localparam int C_LA_W  = ADDR_W - OFFSET_BITS;
  localparam int C_PTR_W = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LINE_W-1:0]   r_arb_rdata;
  logic [ADDR_W-1:0]   r_l2_addr;
  logic [LINE_W-1:0]   r_l2_wdata;

  logic [C_LA_W-1:0]   w_req_line;
  logic                w_rd_req;
  logic                w_wr_req;

  logic                w_hit;
  logic [C_PTR_W-1:0]  w_hit_idx;
  logic [LINE_W-1:0]   w_hit_data;
  logic                w_full;
  logic                w_empty;
  logic [C_LA_W-1:0]   w_head_line;
  logic [LINE_W-1:0]   w_head_data;

  logic                w_push;
  logic                w_pop;
  logic                w_merge;
  logic                w_ld_hit;
  logic                w_ld_l2;
  logic                w_set_rd_addr;
  logic                w_set_wr;

  // Byte offset inside the line never selects anything: the buffer and L2
  // both work on whole lines.
  logic                w_unused_offset;
  assign w_unused_offset = ^arb_addr[OFFSET_BITS-1:0];

  assign w_req_line = arb_addr[ADDR_W-1:OFFSET_BITS];
  // Read wins if both are raised; the write is dropped.
  assign w_rd_req   = arb_read;
  assign w_wr_req   = arb_write & ~arb_read;

  wb_fifo_cam #(
    .LA_W   (C_LA_W),
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_fifo_cam (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_lookup_line (w_req_line),
    .o_hit         (w_hit),
    .o_hit_idx     (w_hit_idx),
    .o_hit_data    (w_hit_data),
    .i_push        (w_push),
    .i_push_line   (w_req_line),
    .i_push_data   (arb_wdata),
    .i_pop         (w_pop),
    .i_merge_en    (w_merge),
    .i_merge_idx   (w_hit_idx),
    .i_merge_data  (arb_wdata),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_line   (w_head_line),
    .o_head_data   (w_head_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the one-cycle datapath strobes that go with each
  // transition.
  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_merge       = 1'b0;
    w_ld_hit      = 1'b0;
    w_ld_l2       = 1'b0;
    w_set_rd_addr = 1'b0;
    w_set_wr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rd_req) begin
          // A buffered line is always newer than L2's copy.
          if (w_hit) begin
            w_ld_hit    = 1'b1;
            w_state_nxt = ACK;
          end else begin
            w_set_rd_addr = 1'b1;
            w_state_nxt   = L2_RD;
          end
        end else if (w_wr_req) begin
          if (w_hit) begin
            w_merge     = 1'b1;
            w_state_nxt = ACK;
          end else if (!w_full) begin
            w_push      = 1'b1;
            w_state_nxt = ACK;
          end else begin
            // Make room; the write stays pending and is retried here.
            w_set_wr    = 1'b1;
            w_state_nxt = L2_WR;
          end
        end else if (!w_empty) begin
          w_set_wr    = 1'b1;
          w_state_nxt = L2_WR;
        end
      end
      L2_RD: begin
        if (l2_resp) begin
          w_ld_l2     = 1'b1;
          w_state_nxt = ACK;
        end
      end
      L2_WR: begin
        if (l2_resp) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    arb_resp = (r_state == ACK);
    l2_read  = (r_state == L2_RD);
    l2_write = (r_state == L2_WR);
  end

  // Address/data registers. The head entry cannot change while in L2_WR,
  // so capturing it on entry is equivalent to driving it live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arb_rdata <= '0;
      r_l2_addr   <= '0;
      r_l2_wdata  <= '0;
    end else begin
      if (w_ld_hit)     r_arb_rdata <= w_hit_data;
      else if (w_ld_l2) r_arb_rdata <= l2_rdata;

      if (w_set_rd_addr) begin
        r_l2_addr <= {w_req_line, {OFFSET_BITS{1'b0}}};
      end else if (w_set_wr) begin
        r_l2_addr  <= {w_head_line, {OFFSET_BITS{1'b0}}};
        r_l2_wdata <= w_head_data;
      end
    end
  end

  assign arb_rdata = r_arb_rdata;
  assign l2_addr   = r_l2_addr;
  assign l2_wdata  = r_l2_wdata;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst_n)
                               !(arb_read && arb_write));

endmodule
`default_nettype wire

// File: tb/tb_arbiter_write_buffer.sv
`default_nettype none
//============================================================================
// Module   : tb_arbiter_write_buffer
// Purpose  : Self-checking bench for arbiter_write_buffer. A line-level
//            model (pending-drain queue, latest-value map, L2 memory) gives
//            the expected read data, drain order and drain contents.
// Revision : 1.0 - initial release
//============================================================================
module tb_arbiter_write_buffer;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 60;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arb_read = 1'b0;
  logic              arb_write = 1'b0;
  logic [ADDR_W-1:0] arb_addr = '0;
  logic [LINE_W-1:0] arb_wdata = '0;
  logic [LINE_W-1:0] arb_rdata;
  logic              arb_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata = '0;
  logic              l2_resp = 1'b0;

  always #5 clk = ~clk;

  arbiter_write_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_read  (arb_read),
    .arb_write (arb_write),
    .arb_addr  (arb_addr),
    .arb_wdata (arb_wdata),
    .arb_rdata (arb_rdata),
    .arb_resp  (arb_resp),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_resp   (l2_resp)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: lines written but not yet seen leaving to L2 (oldest first),
  // the newest value of every written line, and L2's contents.
  logic [31:0]  mq_line[$];
  logic [255:0] mq_data[$];
  logic [255:0] golden[logic [31:0]];
  logic [255:0] l2mem[logic [31:0]];

  bit l2_stall = 1'b1;
  int l2_lat   = 0;
  int l2_cnt   = 0;
  int drains   = 0;

  function automatic logic [31:0] base(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] b);
    return {8{b ^ 32'h5A5A_0000}};
  endfunction

  function automatic int mq_find(input logic [31:0] b);
    foreach (mq_line[i]) if (mq_line[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [255:0] l2_value(input logic [31:0] b);
    return l2mem.exists(b) ? l2mem[b] : init_line(b);
  endfunction

  function automatic logic [255:0] expect_read(input logic [31:0] b);
    return golden.exists(b) ? golden[b] : init_line(b);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // L2 model: responds after l2_lat waiting cycles unless stalled, and
  // checks every drain against the oldest pending line.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || l2_resp) begin
        l2_resp = 1'b0;
        l2_cnt  = 0;
      end else if ((l2_read || l2_write) && !l2_stall) begin
        if (l2_cnt < l2_lat) begin
          l2_cnt++;
        end else begin
          l2_cnt  = 0;
          l2_resp = 1'b1;
          if (l2_read) begin
            l2_rdata = l2_value(l2_addr);
          end else begin
            logic [31:0]  exp_a;
            logic [255:0] exp_d;
            exp_a = (mq_line.size() > 0) ? mq_line[0] : 32'hFFFF_FFFF;
            exp_d = (mq_data.size() > 0) ? mq_data[0] : '0;
            n_vec++;
            if (l2_addr !== exp_a || l2_wdata !== exp_d) begin
              n_bad++;
              $display("FAIL drain_order: got addr %h data %h, required addr %h data %h",
                       l2_addr, l2_wdata, exp_a, exp_d);
            end
            if (mq_line.size() > 0) begin
              void'(mq_line.pop_front());
              void'(mq_data.pop_front());
            end
            l2mem[l2_addr] = l2_wdata;
            drains++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issues one arbiter request and waits (bounded) for arb_resp.
  task automatic arb_req(input bit is_rd, input logic [31:0] a, input logic [255:0] d,
                         output bit ok, output int cyc, output logic [255:0] rd,
                         output bit saw_rd, output bit saw_rd_bad,
                         output logic [31:0] rd_addr, output int lresp_cyc);
    step();
    arb_read  = is_rd;
    arb_write = !is_rd;
    arb_addr  = a;
    arb_wdata = d;
    ok = 0; cyc = 0; rd = '0; saw_rd = 0; saw_rd_bad = 0; rd_addr = '0; lresp_cyc = -1;
    while (!ok && cyc < BUDGET) begin
      step();
      cyc++;
      if (l2_read) begin
        saw_rd  = 1;
        rd_addr = l2_addr;
        if (mq_find(base(a)) >= 0) saw_rd_bad = 1;
      end
      if (l2_resp && l2_read && lresp_cyc < 0) lresp_cyc = cyc;
      if (arb_resp) begin
        ok = 1;
        rd = arb_rdata;
      end
    end
    arb_read  = 1'b0;
    arb_write = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] b, input logic [255:0] d, output bit overflow);
    int idx;
    overflow = 0;
    idx = mq_find(b);
    if (idx >= 0) begin
      mq_data[idx] = d;
    end else begin
      overflow = (mq_line.size() >= DEPTH);
      mq_line.push_back(b);
      mq_data.push_back(d);
    end
    golden[b] = d;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      if (l2_read || l2_write || arb_resp) quiet = 0;
      else quiet++;
      if (quiet >= 6) ok = 1;
    end
  endtask

  task automatic apply_reset();
    arb_read = 1'b0; arb_write = 1'b0; arb_addr = '0; arb_wdata = '0;
    step();
    rst_n = 1'b0;
    mq_line.delete();
    mq_data.delete();
    golden = l2mem;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({arb_resp, l2_read, l2_write} !== 3'b000 || l2_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got resp/rd/wr %b%b%b addr %h, required 000 addr 0",
               arb_resp, l2_read, l2_write, l2_addr);
    end
    n_vec++;
    if (arb_rdata !== '0 || l2_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got rdata %h wdata %h, required 0", arb_rdata, l2_wdata);
    end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    n_vec++;
    if ({arb_resp, l2_read, l2_write} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_quiet: got resp/rd/wr %b%b%b, required 000", arb_resp, l2_read, l2_write);
    end
  endtask

  task automatic test_write_drain();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d1 = rand_line();
    int d0 = drains;
    bit seen = 0;
    l2_stall = 0; l2_lat = 1;
    arb_req(0, 32'h100, d1, ok, cyc, rd, sr, sb, ra, lr);
    model_write(32'h100, d1, ov);
    n_vec++;
    if (!ok || cyc != 1) begin
      n_bad++;
      $display("FAIL wr_latency: got ok=%0d cycles=%0d, required ok=1 cycles=1", ok, cyc);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (l2_write) seen = 1;
    end
    n_vec++;
    if (!seen || l2_addr !== 32'h100 || l2_wdata !== d1) begin
      n_bad++;
      $display("FAIL wr_drain: got seen=%0d addr %h data %h, required addr 100 data %h",
               seen, l2_addr, l2_wdata, d1);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || drains - d0 != 1) begin
      n_bad++;
      $display("FAIL wr_drain_cnt: got idle=%0d drains=%0d, required idle=1 drains=1", ok, drains - d0);
    end
  endtask

  task automatic test_fill_stall();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d;
    bit got = 0;
    l2_stall = 1; l2_lat = 0;
    for (int i = 0; i < 4; i++) begin
      d = rand_line();
      arb_req(0, 32'(i * 32), d, ok, cyc, rd, sr, sb, ra, lr);
      model_write(32'(i * 32), d, ov);
      n_vec++;
      if (!ok || cyc != 1 || ov) begin
        n_bad++;
        $display("FAIL fill_%0d: got ok=%0d cycles=%0d overflow=%0d, required 1/1/0", i, ok, cyc, ov);
      end
    end
    d = rand_line();
    step();
    arb_write = 1'b1; arb_addr = 32'h80; arb_wdata = d;
    for (int i = 0; i < 6; i++) begin
      step();
      if (arb_resp) got = 1;
    end
    n_vec++;
    if (got || !l2_write || l2_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL full_stall: got resp=%0d l2_write=%0d addr %h, required resp=0 l2_write=1 addr 0",
               got, l2_write, l2_addr);
    end
    l2_stall = 0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      step();
      if (arb_resp) got = 1;
    end
    arb_write = 1'b0;
    model_write(32'h80, d, ov);
    n_vec++;
    if (!got || ov) begin
      n_bad++;
      $display("FAIL full_accept: got resp=%0d overflow=%0d, required resp=1 overflow=0", got, ov);
    end
    wait_idle(ok);
  endtask

  task automatic test_read_hit();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d2 = rand_line();
    l2_stall = 1;
    arb_req(0, 32'h200, d2, ok, cyc, rd, sr, sb, ra, lr);
    model_write(32'h200, d2, ov);
    arb_req(1, 32'h21C, '0, ok, cyc, rd, sr, sb, ra, lr);
    n_vec++;
    if (!ok || cyc != 1 || rd !== d2) begin
      n_bad++;
      $display("FAIL rd_hit: got ok=%0d cycles=%0d data %h, required 1/1 data %h", ok, cyc, rd, d2);
    end
    n_vec++;
    if (sr) begin
      n_bad++;
      $display("FAIL rd_hit_l2: got l2_read=1, required 0");
    end
    l2_stall = 0;
    wait_idle(ok);
  endtask

  task automatic test_merge();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d3 = rand_line();
    logic [255:0] d4 = rand_line();
    int d0 = drains;
    l2_stall = 1;
    arb_req(0, 32'h300, d3, ok, cyc, rd, sr, sb, ra, lr);
    model_write(32'h300, d3, ov);
    arb_req(0, 32'h300, d4, ok, cyc, rd, sr, sb, ra, lr);
    model_write(32'h300, d4, ov);
    n_vec++;
    if (!ok || cyc != 1) begin
      n_bad++;
      $display("FAIL merge_ack: got ok=%0d cycles=%0d, required 1/1", ok, cyc);
    end
    l2_stall = 0;
    wait_idle(ok);
    n_vec++;
    if (drains - d0 != 1 || l2mem[32'h300] !== d4) begin
      n_bad++;
      $display("FAIL merge_drain: got drains=%0d data %h, required drains=1 data %h",
               drains - d0, l2mem[32'h300], d4);
    end
  endtask

  task automatic test_read_miss();
    bit ok, sr, sb; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d5 = rand_line();
    l2mem[32'h400]  = d5;
    golden[32'h400] = d5;
    l2_stall = 0; l2_lat = 2;
    arb_req(1, 32'h404, '0, ok, cyc, rd, sr, sb, ra, lr);
    n_vec++;
    if (!sr || ra !== 32'h400) begin
      n_bad++;
      $display("FAIL rd_miss_addr: got l2_read=%0d addr %h, required 1 addr 400", sr, ra);
    end
    n_vec++;
    if (!ok || rd !== d5 || lr < 0 || cyc != lr + 1) begin
      n_bad++;
      $display("FAIL rd_miss_data: got ok=%0d data %h resp_cyc=%0d l2resp_cyc=%0d, required data %h one cycle after l2_resp",
               ok, rd, cyc, lr, d5);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_drain();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [255:0] d6 = rand_line();
    bit seen = 0;
    int d0;
    l2_stall = 1; l2_lat = 1;
    arb_req(0, 32'h500, d6, ok, cyc, rd, sr, sb, ra, lr);
    model_write(32'h500, d6, ov);
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (l2_write) seen = 1;
    end
    d0 = drains;
    rst_n = 1'b0;
    mq_line.delete();
    mq_data.delete();
    golden = l2mem;
    #1;
    n_vec++;
    if (!seen || l2_write !== 1'b0 || l2_addr !== '0) begin
      n_bad++;
      $display("FAIL rst_drain: got seen=%0d l2_write=%0d addr %h, required seen=1 l2_write=0 addr 0",
               seen, l2_write, l2_addr);
    end
    step();
    rst_n = 1'b1;
    l2_stall = 0;
    arb_req(1, 32'h500, '0, ok, cyc, rd, sr, sb, ra, lr);
    n_vec++;
    if (!ok || !sr || rd !== init_line(32'h500) || drains != d0) begin
      n_bad++;
      $display("FAIL rst_reread: got ok=%0d l2_read=%0d data %h drains=%0d, required l2_read=1 data %h drains=0",
               ok, sr, rd, drains - d0, init_line(32'h500));
    end
    wait_idle(ok);
  endtask

  task automatic test_random();
    bit ok, sr, sb, ov; int cyc, lr; logic [255:0] rd; logic [31:0] ra;
    logic [31:0] a;
    logic [255:0] d;
    bit is_rd;
    l2_stall = 0;
    for (int n = 0; n < 250; n++) begin
      is_rd  = 1'($urandom_range(0, 1));
      a      = 32'h1000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
      d      = rand_line();
      l2_lat = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) step();
      arb_req(is_rd, a, d, ok, cyc, rd, sr, sb, ra, lr);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rnd_timeout: op %0d addr %h got no resp, required resp within %0d", n, a, BUDGET);
      end else if (is_rd) begin
        if (rd !== expect_read(base(a)) || sb) begin
          n_bad++;
          $display("FAIL rnd_read: op %0d addr %h got %h l2_read_on_hit=%0d, required %h",
                   n, a, rd, sb, expect_read(base(a)));
        end
      end else begin
        model_write(base(a), d, ov);
        if (ov) begin
          n_bad++;
          $display("FAIL rnd_write: op %0d addr %h acked with %0d lines already pending, required at most %0d",
                   n, a, DEPTH, DEPTH - 1);
        end
      end
      step();
      n_vec++;
      if (arb_resp !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_resp_pulse: op %0d got arb_resp=%b one cycle later, required 0", n, arb_resp);
      end
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || mq_line.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_final_drain: got idle=%0d undrained=%0d, required idle=1 undrained=0",
               ok, mq_line.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_drain();
    test_fill_stall();
    test_read_hit();
    test_merge();
    test_read_miss();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
